// File: rtl/mem_arbiter.sv
// mem_arbiter: services the icache/dcache ports of CPUS cores on a single
// RAM port, one transaction at a time. Data requests beat instruction
// fetches, and each class is picked round-robin from a shared pointer.

// Per-core response side: wait pulses and the held load registers.
module mem_arbiter_port #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ipulse_i,   // I-read of this core completes now
    input  logic              dpulse_i,   // D-read/D-write of this core completes now
    input  logic              drd_i,      // current data transaction is a read
    input  logic [WORD_W-1:0] ramload_i,
    output logic              iwait_o,
    output logic              dwait_o,
    output logic [WORD_W-1:0] iload_o,
    output logic [WORD_W-1:0] dload_o
);
    logic [WORD_W-1:0] iload_q, dload_q;
    logic              dload_en;

    assign dload_en = dpulse_i & drd_i;

    // Capture read data on completion so loads hold between transactions.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            if (ipulse_i) iload_q <= ramload_i;
            if (dload_en) dload_q <= ramload_i;
        end
    end

    // The completing cycle shows ramload directly; otherwise the held value.
    assign iwait_o = ~ipulse_i;
    assign dwait_o = ~dpulse_i;
    assign iload_o = ipulse_i ? ramload_i : iload_q;
    assign dload_o = dload_en ? ramload_i : dload_q;
endmodule

module mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*WORD_W-1:0] iload,
    output logic [CPUS*WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);
    localparam int         IDW       = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RS_ACCESS = 2'd2;

    typedef enum logic { S_IDLE, S_ACCESS } state_e;
    typedef enum logic [1:0] { K_IRD, K_DRD, K_DWR } kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [IDW-1:0]    gnt_q, gnt_d, rr_q, rr_d;
    logic [WORD_W-1:0] addr_q, addr_d, store_q, store_d;

    logic [WORD_W-1:0] iaddr_a  [CPUS];
    logic [WORD_W-1:0] daddr_a  [CPUS];
    logic [WORD_W-1:0] dstore_a [CPUS];
    logic [CPUS-1:0]   dreq;
    logic [IDW:0]      dpick, ipick;
    logic              done;

    // Returns {found, index}: first requester at or after ptr, wrapping.
    function automatic logic [IDW:0] pick(input logic [CPUS-1:0] req,
                                          input logic [IDW-1:0]  ptr);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        // Walk offsets from far to near so the nearest request wins last.
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CPUS;
            if (req[idx]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    // A write strobe alone or together with a read both count as a data request.
    assign dreq  = dREN | dWEN;
    assign dpick = pick(dreq, rr_q);
    assign ipick = pick(iREN, rr_q);
    assign done  = (state_q == S_ACCESS) && (ramstate == RS_ACCESS);

    // Transaction registers; async reset abandons any in-flight access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            kind_q  <= K_IRD;
            gnt_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    // Next state: latch a winner in IDLE, finish only on a RAM ACCESS cycle.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        store_d = store_q;
        case (state_q)
            S_IDLE: begin
                if (dpick[IDW]) begin
                    gnt_d   = dpick[IDW-1:0];
                    kind_d  = dWEN[gnt_d] ? K_DWR : K_DRD;
                    addr_d  = daddr_a[gnt_d];
                    store_d = dstore_a[gnt_d];
                    state_d = S_ACCESS;
                end else if (ipick[IDW]) begin
                    gnt_d   = ipick[IDW-1:0];
                    kind_d  = K_IRD;
                    addr_d  = iaddr_a[gnt_d];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // FREE/BUSY/ERROR all keep the strobes up; ERROR is a silent retry.
                if (done) begin
                    state_d = S_IDLE;
                    rr_d    = (int'(gnt_q) == CPUS - 1) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ramREN   = (state_q == S_ACCESS) && (kind_q != K_DWR);
    assign ramWEN   = (state_q == S_ACCESS) && (kind_q == K_DWR);
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    for (genvar n = 0; n < CPUS; n++) begin : g_port
        logic hit;
        assign iaddr_a[n]  = iaddr[n*WORD_W +: WORD_W];
        assign daddr_a[n]  = daddr[n*WORD_W +: WORD_W];
        assign dstore_a[n] = dstore[n*WORD_W +: WORD_W];
        assign hit         = done && (int'(gnt_q) == n);

        mem_arbiter_port #(.WORD_W(WORD_W)) u_port (
            .CLK       (CLK),
            .nRST      (nRST),
            .ipulse_i  (hit && (kind_q == K_IRD)),
            .dpulse_i  (hit && (kind_q != K_IRD)),
            .drd_i     (kind_q == K_DRD),
            .ramload_i (ramload),
            .iwait_o   (iwait[n]),
            .dwait_o   (dwait[n]),
            .iload_o   (iload[n*WORD_W +: WORD_W]),
            .dload_o   (dload[n*WORD_W +: WORD_W])
        );
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset checks, a cycle table for the directed
// scenarios, async-reset abort sequence, then random traffic vs a model.
module tb_mem_arbiter;
    localparam int CPUS = 2;
    localparam int W    = 32;
    localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [CPUS-1:0]   iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS*W-1:0] iaddr, daddr, dstore, iload, dload;
    logic              ramREN, ramWEN;
    logic [W-1:0]      ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .iwait(iwait),
        .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, ".iwait"}, iwait, 2'b11);
        chk({tag, ".dwait"}, dwait, 2'b11);
        chk({tag, ".ramREN"}, ramREN, 1'b0);
        chk({tag, ".ramWEN"}, ramWEN, 1'b0);
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic [1:0]  iren, dren, dwen, rs;
        logic [31:0] rload;
        logic [1:0]  e_iwait, e_dwait;
        logic        e_ren, e_wen, chk_bus;
        logic [31:0] e_addr, e_store;
        logic [63:0] e_iload, e_dload;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [1:0] ir, dr, dw, rs, input logic [31:0] rl,
                       input logic [1:0] ei, ed, input logic er, ew, cb,
                       input logic [31:0] ea, es, input logic [63:0] eil, edl);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs; v.rload = rl;
        v.e_iwait = ei; v.e_dwait = ed; v.e_ren = er; v.e_wen = ew;
        v.chk_bus = cb; v.e_addr = ea; v.e_store = es;
        v.e_iload = eil; v.e_dload = edl;
        tbl.push_back(v);
    endtask

    // ---------------- random-phase reference model ----------------
    bit          m_busy;
    int          m_core, m_kind;        // kind: 0 fetch, 1 data read, 2 data write
    logic [31:0] m_addr, m_store;
    int          m_ptr;
    logic [31:0] m_iload [CPUS];
    logic [31:0] m_dload [CPUS];
    logic [31:0] mem [int];
    bit          rq_i [CPUS];
    bit          rq_d [CPUS];
    bit          rq_w [CPUS];
    bit          rq_both [CPUS];
    logic [31:0] rq_ia [CPUS];
    logic [31:0] rq_da [CPUS];
    logic [31:0] rq_ds [CPUS];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return ~a;
    endfunction

    initial begin
        logic [63:0] IL, DL;
        iREN = '0; dREN = '0; dWEN = '0; ramstate = F; ramload = '0;
        iaddr  = {32'h0000_0000, 32'h0000_0040};
        daddr  = {32'h0000_0100, 32'h0000_0080};
        dstore = {32'h1234_5678, 32'h0000_0000};
        nRST = 1'b0;

        // Reset state, observed before any clock edge
        #2;
        chk_idle_out("rst0");
        chk("rst0.ramaddr", ramaddr, 32'h0);
        chk("rst0.ramstore", ramstore, 32'h0);
        chk("rst0.iload", iload, 64'h0);
        chk("rst0.dload", dload, 64'h0);
        #20 nRST = 1'b1;                  // released mid-cycle (t=22)
        @(posedge CLK); #1;
        for (int c = 0; c < 3; c++) begin
            #3 chk_idle_out($sformatf("norq%0d", c));
            @(posedge CLK); #1;
        end

        // Fetch with BUSY x2; fetch+data; write with ERROR x2; alternating reads
        IL = 64'h0000_0000_DEAD_BEEF;
        DL = 64'h0000_0000_1111_1111;
        add(2'b01,2'b00,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,64'h0,64'h0);
        add(2'b01,2'b00,2'b00,B,32'h0,          2'b11,2'b11,1,0,1,32'h40,32'h0,64'h0,64'h0);
        add(2'b01,2'b00,2'b00,B,32'h0,          2'b11,2'b11,1,0,1,32'h40,32'h0,64'h0,64'h0);
        add(2'b01,2'b00,2'b00,A,32'hDEAD_BEEF,  2'b10,2'b11,1,0,1,32'h40,32'h0,IL,64'h0);
        add(2'b00,2'b00,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,64'h0);
        add(2'b01,2'b01,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,64'h0);
        add(2'b01,2'b01,2'b00,A,32'h1111_1111,  2'b11,2'b10,1,0,1,32'h80,32'h0,IL,DL);
        add(2'b01,2'b00,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        IL = 64'h0000_0000_2222_2222;
        add(2'b01,2'b00,2'b00,A,32'h2222_2222,  2'b10,2'b11,1,0,1,32'h40,32'h0,IL,DL);
        add(2'b00,2'b00,2'b10,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        add(2'b00,2'b00,2'b10,E,32'h0,          2'b11,2'b11,0,1,1,32'h100,32'h1234_5678,IL,DL);
        add(2'b00,2'b00,2'b10,E,32'h0,          2'b11,2'b11,0,1,1,32'h100,32'h1234_5678,IL,DL);
        add(2'b00,2'b00,2'b10,A,32'h5555_5555,  2'b11,2'b01,0,1,1,32'h100,32'h1234_5678,IL,DL);
        add(2'b00,2'b00,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        add(2'b00,2'b11,2'b00,A,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        DL = 64'h0000_0000_0000_00A0;
        add(2'b00,2'b11,2'b00,A,32'hA0,         2'b11,2'b10,1,0,1,32'h80,32'h0,IL,DL);
        add(2'b00,2'b11,2'b00,A,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        DL = 64'h0000_00A1_0000_00A0;
        add(2'b00,2'b11,2'b00,A,32'hA1,         2'b11,2'b01,1,0,1,32'h100,32'h0,IL,DL);
        add(2'b00,2'b11,2'b00,A,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        DL = 64'h0000_00A1_0000_00A2;
        add(2'b00,2'b11,2'b00,A,32'hA2,         2'b11,2'b10,1,0,1,32'h80,32'h0,IL,DL);
        add(2'b00,2'b00,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);
        add(2'b00,2'b00,2'b00,F,32'h0,          2'b11,2'b11,0,0,0,32'h0,32'h0,IL,DL);

        foreach (tbl[i]) begin
            iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
            ramstate = tbl[i].rs; ramload = tbl[i].rload;
            #3;
            chk($sformatf("v%0d.iwait", i), iwait, tbl[i].e_iwait);
            chk($sformatf("v%0d.dwait", i), dwait, tbl[i].e_dwait);
            chk($sformatf("v%0d.ramREN", i), ramREN, tbl[i].e_ren);
            chk($sformatf("v%0d.ramWEN", i), ramWEN, tbl[i].e_wen);
            chk($sformatf("v%0d.iload", i), iload, tbl[i].e_iload);
            chk($sformatf("v%0d.dload", i), dload, tbl[i].e_dload);
            if (tbl[i].chk_bus) chk($sformatf("v%0d.ramaddr", i), ramaddr, tbl[i].e_addr);
            if (tbl[i].e_wen) chk($sformatf("v%0d.ramstore", i), ramstore, tbl[i].e_store);
            @(posedge CLK); #1;
        end

        // Reset during a core0 read: strobe drops at once, no wait pulse, re-grant
        dREN = 2'b01; ramstate = B;
        #3 chk("ab.idle.ramREN", ramREN, 1'b0);
        @(posedge CLK); #1;
        #3 chk("ab.acc.ramREN", ramREN, 1'b1);
        #1 nRST = 1'b0; ramstate = A; ramload = 32'hBAD0_BAD0;
        #1;
        chk("ab.rst.ramREN", ramREN, 1'b0);
        chk("ab.rst.dwait", dwait, 2'b11);
        chk("ab.rst.dload", dload, 64'h0);
        chk("ab.rst.ramaddr", ramaddr, 32'h0);
        #2 nRST = 1'b1;
        #1 chk_idle_out("ab.rel");
        @(posedge CLK); #1;
        ramload = 32'hBEEF_0006;
        #3;
        chk("ab.regrant.ramREN", ramREN, 1'b1);
        chk("ab.regrant.ramaddr", ramaddr, 32'h80);
        chk("ab.regrant.dwait", dwait, 2'b10);
        chk("ab.regrant.dload", dload, 64'h0000_0000_BEEF_0006);
        @(posedge CLK); #1;
        dREN = '0; ramstate = F;

        // Fresh reset before random traffic
        nRST = 1'b0; #3 nRST = 1'b1;
        @(posedge CLK); #1;
        m_busy = 0; m_ptr = 0; m_core = 0; m_kind = 0; m_addr = '0; m_store = '0;
        for (int n = 0; n < CPUS; n++) begin
            m_iload[n] = '0; m_dload[n] = '0; rq_i[n] = 0; rq_d[n] = 0;
            rq_w[n] = 0; rq_both[n] = 0; rq_ia[n] = '0; rq_da[n] = '0; rq_ds[n] = '0;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0]        ei, ed, rs;
            logic [CPUS*W-1:0] eil, edl;
            bit                pulse;
            // requesters start new requests only when idle, then hold them
            for (int n = 0; n < CPUS; n++) begin
                if (!rq_i[n] && $urandom_range(0, 3) == 0) begin
                    rq_i[n] = 1; rq_ia[n] = 32'($urandom_range(0, 15) * 4);
                end
                if (!rq_d[n] && $urandom_range(0, 2) == 0) begin
                    rq_d[n] = 1; rq_w[n] = 1'($urandom_range(0, 1));
                    rq_both[n] = ($urandom_range(0, 3) == 0);
                    rq_da[n] = 32'($urandom_range(0, 15) * 4); rq_ds[n] = $urandom;
                end
                iREN[n] = rq_i[n];
                dREN[n] = rq_d[n] && (!rq_w[n] || rq_both[n]);
                dWEN[n] = rq_d[n] && rq_w[n];
                iaddr[n*W +: W] = rq_ia[n];
                daddr[n*W +: W] = rq_da[n];
                dstore[n*W +: W] = rq_ds[n];
            end
            rs = 2'($urandom_range(0, 3));
            ramstate = rs;
            ramload = m_busy ? memrd(m_addr) : $urandom;

            pulse = m_busy && (rs == A);
            ei = 2'b11; ed = 2'b11;
            for (int n = 0; n < CPUS; n++) begin
                eil[n*W +: W] = m_iload[n];
                edl[n*W +: W] = m_dload[n];
            end
            if (pulse) begin
                if (m_kind == 0) begin ei[m_core] = 1'b0; eil[m_core*W +: W] = ramload; end
                else ed[m_core] = 1'b0;
                if (m_kind == 1) edl[m_core*W +: W] = ramload;
            end
            #3;
            chk($sformatf("r%0d.iwait", cyc), iwait, ei);
            chk($sformatf("r%0d.dwait", cyc), dwait, ed);
            chk($sformatf("r%0d.ramREN", cyc), ramREN, m_busy && m_kind != 2);
            chk($sformatf("r%0d.ramWEN", cyc), ramWEN, m_busy && m_kind == 2);
            chk($sformatf("r%0d.iload", cyc), iload, eil);
            chk($sformatf("r%0d.dload", cyc), dload, edl);
            if (m_busy) chk($sformatf("r%0d.ramaddr", cyc), ramaddr, m_addr);
            if (m_busy && m_kind == 2) chk($sformatf("r%0d.ramstore", cyc), ramstore, m_store);

            // advance the model across the coming edge
            if (m_busy) begin
                if (pulse) begin
                    if (m_kind == 2) mem[int'(m_addr)] = m_store;
                    else if (m_kind == 0) m_iload[m_core] = ramload;
                    else m_dload[m_core] = ramload;
                    if (m_kind == 0) rq_i[m_core] = 0; else rq_d[m_core] = 0;
                    m_ptr = (m_core + 1) % CPUS;
                    m_busy = 0;
                end
            end else begin
                for (int k = 0; k < CPUS && !m_busy; k++) begin
                    int n;
                    n = (m_ptr + k) % CPUS;
                    if (rq_d[n]) begin
                        m_busy = 1; m_core = n; m_kind = rq_w[n] ? 2 : 1;
                        m_addr = rq_da[n]; m_store = rq_ds[n];
                    end
                end
                for (int k = 0; k < CPUS && !m_busy; k++) begin
                    int n;
                    n = (m_ptr + k) % CPUS;
                    if (rq_i[n]) begin
                        m_busy = 1; m_core = n; m_kind = 0; m_addr = rq_ia[n];
                    end
                end
            end
            @(posedge CLK); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache_control protocol driven by each core's icache/dcache pair.
- Accepts instruction fetches and data read/write requests from CPUS cores.
- Arbitrates them onto a single-ported RAM, one transaction at a time.
- Returns wait/load responses to the requesting cache.

Parameters:
CPUS, 2, number of cores (each with one icache and one dcache request port)
WORD_W, 32, address/data width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  CPUS  instruction read request per core
iaddr  in  CPUS*WORD_W  instruction address per core (core n at bits [n*WORD_W +: WORD_W])
dREN  in  CPUS  data read request per core
dWEN  in  CPUS  data write request per core
daddr  in  CPUS*WORD_W  data address per core
dstore  in  CPUS*WORD_W  data write value per core
iwait  out  CPUS  1 = instruction request not yet serviced
dwait  out  CPUS  1 = data request not yet serviced
iload  out  CPUS*WORD_W  instruction read data per core
dload  out  CPUS*WORD_W  data read data per core
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS (done this cycle), 3=ERROR

Behaviour:
- Reset (async, nRST=0):
  - State goes to IDLE; round-robin pointer to core 0.
  - All iwait/dwait = 1; iload/dload = 0.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
- Requester rules:
  - A cache holds REN/WEN, address and store data stable until its wait goes low.
  - dREN and dWEN from the same core are never both high; if both are, treat as a write.
- FSM states: IDLE, ACCESS.
- IDLE, selection:
  - Data requests beat instruction requests.
  - Within a class, the lowest core index at or after the round-robin pointer wins, wrapping mod CPUS.
  - The winner's core id, type (I-read, D-read, D-write), address and store data are registered on the clock edge.
  - State moves to ACCESS on that edge.
  - No request pending: stay in IDLE.
- ACCESS:
  - ramREN/ramWEN, ramaddr and ramstore are driven from the registered values.
  - While ramstate is FREE or BUSY: hold all outputs.
  - ramstate == ERROR: hold strobes and retry; no response is given.
  - ramstate == ACCESS: combinationally drive the granted core's iwait or dwait = 0 for that cycle only.
  - On a read, the granted iload/dload = ramload in that cycle; loads are otherwise held at their last value.
  - On the next edge: state returns to IDLE, strobes drop to 0, and the pointer moves to (granted core + 1) mod CPUS.
- Latency:
  - Request seen in IDLE at cycle 0 → strobes in cycle 1 → earliest wait low in cycle 1.
  - There is one IDLE cycle between back-to-back transactions.
- Wait lines of non-granted ports stay 1 throughout.
- Requester drops its request mid-ACCESS: the transaction still completes on RAM (a write is committed); the wait-low pulse is still issued.
- Reset asserted mid-ACCESS: strobes drop immediately (async); the transaction is abandoned and no wait-low is issued.
- Starvation-free: any pending data request is granted within CPUS data transactions.
- An icache request waits only while data requests are pending.

Test Plan:
- Reset, then no requests → iwait=2'b11, dwait=2'b11, ramREN=ramWEN=0 indefinitely; assert/release nRST mid-cycle, outputs change without a clock edge.
- Core0 iREN, iaddr=0x0000_0040, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEAD_BEEF → ramREN=1 with ramaddr=0x40 from cycle 1; iwait[0]=0 and iload[0]=0xDEADBEEF in cycle 3 only.
- Core0 iREN and dREN together (daddr=0x80) → data serviced first (ramaddr=0x80); fetch follows after one IDLE cycle.
- Both cores hold dREN continuously, zero-latency RAM → grants alternate 0,1,0,1; dwait low once per 2 transactions per core.
- Core1 dWEN, daddr=0x100, dstore=0x1234_5678; RAM gives ERROR twice, then ACCESS → ramWEN held for all 3 cycles with stable address/data; dwait[1] low only on the ACCESS cycle.
- nRST pulsed low during ACCESS of a core0 read → ramREN=0 immediately, dwait[0] stays 1; after release, the request (still held) is re-granted from IDLE.
